mxu_result_drain: RTL and testbench
===================================

# mxu_result_drain

Downstream drain stage of the MXU top: once the LSU arms it, it captures the 16-row result array the MXU presents on `top_lsu_data_rdy` and serialises it into 128-bit beats on a valid/ready SRAM write port. In int8 mode it writes one beat per row; in int16 mode it writes two beats per row. It frees the LSU from holding the MXU result bus for the whole write-back.

## Interface
- `ADDR_W`, 16, width of the write address; addresses wrap modulo 2^ADDR_W
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `lsu_drain_vld`  in  1  drain request; accepted when `drain_lsu_rdy`=1
- `lsu_drain_mode`  in  1  0 = int8 (16 beats), 1 = int16 (32 beats); sampled on accept
- `lsu_drain_base_addr`  in  ADDR_W  address of first beat; sampled on accept
- `drain_lsu_rdy`  out  1  block is IDLE and can accept a request
- `top_lsu_data_rdy`  in  1  MXU result rows valid this cycle
- `top_lsu_int8_data`  in  2048  row r at bits [128r+127:128r], r=0..15
- `top_lsu_int16_data`  in  4096  row r at bits [256r+255:256r]
- `drain_mem_vld`  out  1  write beat valid
- `drain_mem_addr`  out  ADDR_W  write address
- `drain_mem_data`  out  128  write data
- `mem_drain_rdy`  in  1  write port accepts the beat when vld&rdy
- `drain_lsu_done`  out  1  one-cycle pulse after the last beat is accepted
- `drain_busy`  out  1  state ≠ IDLE

## Operation
- Buffer: 32 entries × 128 b.
  - int8 capture: entry r = int8 row r.
  - int16 capture: entry 2r = int16 row r [127:0], entry 2r+1 = row r [255:128].
- FSM states: IDLE, WAIT_DATA, SEND, DONE.
  - IDLE: `drain_lsu_rdy`=1. On `lsu_drain_vld`, latch mode and base, clear beat counter, and go to WAIT_DATA. `top_lsu_data_rdy` is ignored in IDLE.
  - WAIT_DATA: on `top_lsu_data_rdy`=1, capture all rows for the latched mode into the buffer and go to SEND. Otherwise hold.
  - SEND: `drain_mem_vld`=1, `drain_mem_data`=buf[cnt], `drain_mem_addr`=base+cnt (truncated to ADDR_W, wraps).
    - On vld&rdy, cnt increments.
    - When beat LAST is accepted (LAST = 15 in int8, 31 in int16), go to DONE.
  - DONE: `drain_lsu_done`=1 for exactly one cycle, then go to IDLE.
- While `drain_mem_vld`=1 and `mem_drain_rdy`=0, addr and data are held stable. Vld never drops before the beat is accepted.
- `top_lsu_data_rdy` in SEND or DONE is ignored; the buffer is not overwritten.
- A new `lsu_drain_vld` is only accepted in IDLE. Requests in other states are not latched; the LSU holds vld until rdy.
- Beat counter is 5 bits; in int8 mode bit 4 is always 0.

## Timing
- Reset (sync, rst_n=0 at a rising edge): state=IDLE, cnt=0, mode=0, base=0.
  - Outputs after reset: `drain_lsu_rdy`=1, `drain_mem_vld`=0, `drain_mem_addr`=0, `drain_mem_data`=0, `drain_lsu_done`=0, `drain_busy`=0.
  - Buffer contents are don't-care.
  - Reset mid-SEND aborts the transfer; no done pulse follows.
- All outputs are decoded from registered state, cnt and buffer; there is no combinational path from inputs to outputs.
- Request accepted at edge N → WAIT_DATA from N+1.
- `top_lsu_data_rdy` sampled at edge M (in WAIT_DATA) → first beat valid from M+1.
- With `mem_drain_rdy` tied high:
  - int8: beats on cycles M+1..M+16, done pulse at M+17, `drain_lsu_rdy` at M+18.
  - int16: beats on cycles M+1..M+32, done pulse at M+33, `drain_lsu_rdy` at M+34.
- Each cycle of `mem_drain_rdy`=0 during SEND adds exactly one cycle of latency.
- `top_lsu_data_rdy` asserted in the same cycle that `lsu_drain_vld` is accepted is not captured; capture starts in WAIT_DATA.

## Test plan
- Reset values: hold rst_n=0 for 3 cycles with random inputs → all outputs at reset values, `drain_lsu_rdy`=1.
- int8 basic:
  - Stimulus: mode=0, base=0x0100, int8 row r = {16{8'(r+1)}}, data_rdy one cycle later, mem rdy=1.
  - Response: 16 consecutive beats, addr 0x0100..0x010F, beat r data = {16{8'(r+1)}}, done pulse at M+17.
- int16 split:
  - Stimulus: mode=1, base=0, int16 row r lower half = {8{16'(r)}}, upper half = {8{16'(0x100+r)}}.
  - Response: 32 beats; beat 2r = {8{16'(r)}}, beat 2r+1 = {8{16'(0x100+r)}}; addr 0..31; done at M+33.
- Backpressure: int8 run with `mem_drain_rdy` = 1,0,0,1 repeating → addr/data stable during stalls, each beat accepted exactly once, done after the 16th accepted beat.
- Wrap and ignore:
  - Stimulus: base=0xFFF8, mode=0; change the row data and pulse data_rdy again during SEND.
  - Response: addresses 0xFFF8..0xFFFF, then 0x0000..0x0007; output data equals the first capture.
- Abort:
  - Stimulus: rst_n=0 at beat 5 of an int16 run, then a new int8 request.
  - Response: vld drops at that edge with no done pulse; the new run completes normally with 16 beats.

Source files
------------

// File: rtl/mxu_result_drain.sv
// mxu_result_drain: captures the MXU result rows once the LSU arms it and
// writes them out as 128-bit beats on a valid/ready SRAM write port.
// int8 mode writes one beat per row (16 beats). int16 mode writes the low half
// and then the high half of each row (32 beats).
//
// Handshake: a beat transfers on any rising edge where drain_mem_vld and
// mem_drain_rdy are both 1. Once vld rises it stays high, and addr/data stay
// stable, until that beat transfers. The LSU request transfers on
// lsu_drain_vld & drain_lsu_rdy.
module mxu_result_drain #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_drain_vld,
  input  logic              lsu_drain_mode,
  input  logic [ADDR_W-1:0] lsu_drain_base_addr,
  output logic              drain_lsu_rdy,
  input  logic              top_lsu_data_rdy,
  input  logic [2047:0]     top_lsu_int8_data,
  input  logic [4095:0]     top_lsu_int16_data,
  output logic              drain_mem_vld,
  output logic [ADDR_W-1:0] drain_mem_addr,
  output logic [127:0]      drain_mem_data,
  input  logic              mem_drain_rdy,
  output logic              drain_lsu_done,
  output logic              drain_busy,
  output logic [1:0]        drain_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    SEND      = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [4:0]        cnt_q;
  logic              mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [127:0]      buf_q [32];

  logic accept;
  logic capture;
  logic beat_fire;
  logic last_beat;

  assign accept    = (state_q == IDLE) && lsu_drain_vld;
  assign capture   = (state_q == WAIT_DATA) && top_lsu_data_rdy;
  assign beat_fire = (state_q == SEND) && mem_drain_rdy;
  assign last_beat = (cnt_q == (mode_q ? 5'd31 : 5'd15));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (lsu_drain_vld) state_d = WAIT_DATA;
      WAIT_DATA: if (top_lsu_data_rdy) state_d = SEND;
      SEND:      if (mem_drain_rdy && last_beat) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request latch and beat counter; counter returns to 0 after the last beat
  // so bit 4 never sets in int8 mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      base_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      mode_q <= lsu_drain_mode;
      base_q <= lsu_drain_base_addr;
    end else if (beat_fire) begin
      cnt_q  <= last_beat ? 5'd0 : cnt_q + 5'd1;
    end
  end

  // Result buffer: loaded once per request, contents otherwise don't-care
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < 16; r++) begin
        if (mode_q) begin
          buf_q[2*r]   <= top_lsu_int16_data[256*r +: 128];
          buf_q[2*r+1] <= top_lsu_int16_data[256*r+128 +: 128];
        end else begin
          buf_q[r]     <= top_lsu_int8_data[128*r +: 128];
        end
      end
    end
  end

  // Outputs come only from registered state, counter and buffer
  assign drain_lsu_rdy  = (state_q == IDLE);
  assign drain_busy     = (state_q != IDLE);
  assign drain_lsu_done = (state_q == DONE);
  assign drain_mem_vld  = (state_q == SEND);
  assign drain_mem_addr = drain_mem_vld ? base_q + ADDR_W'(cnt_q) : '0;
  assign drain_mem_data = drain_mem_vld ? buf_q[cnt_q] : '0;
  assign drain_state    = state_q;

endmodule

// File: tb/tb_mxu_result_drain.sv
// Bench for mxu_result_drain: directed runs plus randomized runs, with the
// expected beat stream built from the captured rows by a queue model.
module tb_mxu_result_drain;

  logic          clk;
  logic          rst_n;
  logic          lsu_drain_vld;
  logic          lsu_drain_mode;
  logic [15:0]   lsu_drain_base_addr;
  logic          drain_lsu_rdy;
  logic          top_lsu_data_rdy;
  logic [2047:0] top_lsu_int8_data;
  logic [4095:0] top_lsu_int16_data;
  logic          drain_mem_vld;
  logic [15:0]   drain_mem_addr;
  logic [127:0]  drain_mem_data;
  logic          mem_drain_rdy;
  logic          drain_lsu_done;
  logic          drain_busy;
  logic [1:0]    drain_state;

  int compared   = 0;
  int mismatched = 0;

  logic [2047:0] cap8;
  logic [4095:0] cap16;
  logic [127:0]  exp_q[$];
  logic [15:0]   exp_a[$];

  mxu_result_drain #(.ADDR_W(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lsu_drain_vld       (lsu_drain_vld),
    .lsu_drain_mode      (lsu_drain_mode),
    .lsu_drain_base_addr (lsu_drain_base_addr),
    .drain_lsu_rdy       (drain_lsu_rdy),
    .top_lsu_data_rdy    (top_lsu_data_rdy),
    .top_lsu_int8_data   (top_lsu_int8_data),
    .top_lsu_int16_data  (top_lsu_int16_data),
    .drain_mem_vld       (drain_mem_vld),
    .drain_mem_addr      (drain_mem_addr),
    .drain_mem_data      (drain_mem_data),
    .mem_drain_rdy       (mem_drain_rdy),
    .drain_lsu_done      (drain_lsu_done),
    .drain_busy          (drain_busy),
    .drain_state         (drain_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  task automatic rand_rows(output logic [2047:0] r8, output logic [4095:0] r16);
    for (int w = 0; w < 64; w++)  r8[32*w +: 32]  = $urandom();
    for (int w = 0; w < 128; w++) r16[32*w +: 32] = $urandom();
  endtask

  // One drain request. bp: 0 = rdy tied high, 1 = 1,0,0,1 pattern, 2 = random.
  // redo re-pulses data_rdy with new rows mid-SEND; abort_at >= 0 resets the
  // block while that beat index is on the port.
  task automatic run_drain(input logic m, input logic [15:0] b, input int bp,
                           input bit redo, input int abort_at);
    int nb, k, acc, dly;
    bit finished;
    logic r;
    logic [2047:0] g8;
    logic [4095:0] g16;
    logic [3:0] pat;
    pat = 4'b1001;
    nb = m ? 32 : 16;
    exp_q.delete();
    exp_a.delete();
    for (int i = 0; i < 16; i++) begin
      if (m) begin
        exp_q.push_back(cap16[256*i +: 128]);
        exp_q.push_back(cap16[256*i+128 +: 128]);
      end else begin
        exp_q.push_back(cap8[128*i +: 128]);
      end
    end
    for (int i = 0; i < nb; i++) exp_a.push_back(16'(b + 16'(i)));

    @(negedge clk);
    chk("idle_rdy", drain_lsu_rdy, 1'b1);
    chk("idle_busy", drain_busy, 1'b0);
    // Request, with a data_rdy in the same cycle that must not be captured
    lsu_drain_vld       = 1'b1;
    lsu_drain_mode      = m;
    lsu_drain_base_addr = b;
    top_lsu_data_rdy    = 1'b1;
    top_lsu_int8_data   = ~cap8;
    top_lsu_int16_data  = ~cap16;
    @(negedge clk);
    chk("wait_busy", drain_busy, 1'b1);
    chk("wait_rdy", drain_lsu_rdy, 1'b0);
    chk("wait_vld", drain_mem_vld, 1'b0);
    // Inputs changed after accept must not affect the latched request
    lsu_drain_vld       = 1'b1;
    lsu_drain_mode      = ~m;
    lsu_drain_base_addr = 16'($urandom());
    top_lsu_data_rdy    = 1'b0;
    dly = $urandom_range(0, 2);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk("wait_hold_vld", drain_mem_vld, 1'b0);
      chk("wait_hold_busy", drain_busy, 1'b1);
    end
    lsu_drain_vld      = 1'b0;
    top_lsu_int8_data  = cap8;
    top_lsu_int16_data = cap16;
    top_lsu_data_rdy   = 1'b1;
    @(negedge clk);
    top_lsu_data_rdy = 1'b0;
    rand_rows(g8, g16);
    top_lsu_int8_data  = g8;
    top_lsu_int16_data = g16;

    finished = 1'b0;
    acc = 0;
    k = 1;
    while (k <= 300 && !finished) begin
      if (abort_at >= 0 && acc == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_vld", drain_mem_vld, 1'b0);
        chk("abort_done", drain_lsu_done, 1'b0);
        chk("abort_rdy", drain_lsu_rdy, 1'b1);
        chk("abort_busy", drain_busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", drain_lsu_done, 1'b0);
        return;
      end
      if (exp_q.size() > 0) begin
        chk("beat_vld", drain_mem_vld, 1'b1);
        chk("beat_addr", drain_mem_addr, exp_a[0]);
        chk("beat_data", drain_mem_data, exp_q[0]);
        chk("beat_no_done", drain_lsu_done, 1'b0);
        if (bp == 0)      r = 1'b1;
        else if (bp == 1) r = pat[(k-1) % 4];
        else              r = 1'($urandom_range(0, 1));
        mem_drain_rdy = r;
        if (r) begin
          void'(exp_q.pop_front());
          void'(exp_a.pop_front());
          acc++;
        end
        if (redo && k == 3) begin
          rand_rows(g8, g16);
          top_lsu_int8_data  = g8;
          top_lsu_int16_data = g16;
          top_lsu_data_rdy   = 1'b1;
        end else begin
          top_lsu_data_rdy = 1'b0;
        end
      end else begin
        chk("done_pulse", drain_lsu_done, 1'b1);
        chk("done_vld", drain_mem_vld, 1'b0);
        chk("done_busy", drain_busy, 1'b1);
        if (bp == 0) chk("done_latency", 128'(k), 128'(nb + 1));
        chk("beats_accepted", 128'(acc), 128'(nb));
        mem_drain_rdy = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("post_done", drain_lsu_done, 1'b0);
        chk("post_rdy", drain_lsu_rdy, 1'b1);
        chk("post_vld", drain_mem_vld, 1'b0);
        finished = 1'b1;
      end
      if (!finished) begin
        @(negedge clk);
        k++;
      end
    end
    chk("drain_completed", 128'(finished), 128'(1));
    mem_drain_rdy = 1'b1;
  endtask

  // Directed sequence followed by randomized runs
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lsu_drain_vld       = 1'($urandom_range(0, 1));
      lsu_drain_mode      = 1'($urandom_range(0, 1));
      lsu_drain_base_addr = 16'($urandom());
      top_lsu_data_rdy    = 1'($urandom_range(0, 1));
      mem_drain_rdy       = 1'($urandom_range(0, 1));
      rand_rows(top_lsu_int8_data, top_lsu_int16_data);
      @(negedge clk);
    end
    chk("rst_rdy", drain_lsu_rdy, 1'b1);
    chk("rst_vld", drain_mem_vld, 1'b0);
    chk("rst_addr", drain_mem_addr, 16'h0);
    chk("rst_data", drain_mem_data, 128'h0);
    chk("rst_done", drain_lsu_done, 1'b0);
    chk("rst_busy", drain_busy, 1'b0);
    rst_n = 1'b1;
    lsu_drain_vld    = 1'b0;
    top_lsu_data_rdy = 1'b0;
    mem_drain_rdy    = 1'b1;
    @(negedge clk);
    chk("idle_after_rst_rdy", drain_lsu_rdy, 1'b1);

    // int8 basic
    cap16 = '0;
    for (int r = 0; r < 16; r++) cap8[128*r +: 128] = {16{8'(r + 1)}};
    run_drain(1'b0, 16'h0100, 0, 1'b0, -1);

    // int16 split
    for (int r = 0; r < 16; r++) begin
      cap16[256*r +: 128]     = {8{16'(r)}};
      cap16[256*r+128 +: 128] = {8{16'(16'h100 + r)}};
    end
    run_drain(1'b1, 16'h0000, 0, 1'b0, -1);

    // Backpressure 1,0,0,1
    rand_rows(cap8, cap16);
    run_drain(1'b0, 16'h2340, 1, 1'b0, -1);

    // Address wrap with a second data_rdy pulse during SEND
    rand_rows(cap8, cap16);
    run_drain(1'b0, 16'hFFF8, 0, 1'b1, -1);

    // Abort an int16 run at beat 5, then a normal int8 run
    rand_rows(cap8, cap16);
    run_drain(1'b1, 16'h0400, 0, 1'b0, 5);
    rand_rows(cap8, cap16);
    run_drain(1'b0, 16'h0800, 0, 1'b0, -1);

    // Randomized runs
    for (int t = 0; t < 6; t++) begin
      rand_rows(cap8, cap16);
      run_drain(1'($urandom_range(0, 1)), 16'($urandom()), 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
